trap_ctrl: RTL and testbench

- Sequences the machine-mode CSR file on traps.
- Decides when an exception, interrupt or MRET is taken, and drains the pipeline for interrupts.
- Drives the CSR update strobes (mepc/mcause/mstatus via mcause_update, is_mret) and the PC redirect to the fetch stage.
- Sits between the WB stage, the interrupt sources and the CSR block.

---
 rtl/trap_ctrl_if.sv | 59 +++++
 rtl/trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: shared types plus the bundle between WB, interrupt sources,
// the CSR block and fetch on one side and trap_ctrl on the other.
// Optional: TRAP_CTRL_NMI_EN adds the nmi input.
package trap_ctrl_pkg;
  typedef enum logic {MEPC_PC_WB = 1'b0, MEPC_PC_IF = 1'b1} mepc_mux_e;
  typedef logic [5:0] mcause_e;  // [5] interrupt, [4:0] code
endpackage

interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic        wb_valid;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        mret_wb;
  logic        pipe_busy;
  logic        extern_intr;
  logic        timer_intr;
  logic        software_intr;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
`ifdef TRAP_CTRL_NMI_EN
  logic        nmi;
`endif
  logic        halt_if;
  logic        flush_req;
  logic        pc_set;
  logic [31:0] pc_target;
  logic        mepc_updata;
  mepc_mux_e   mepc_mux;
  logic        mcause_update;
  mcause_e     mcause;
  logic        is_mret;
  logic        trap_busy;

  // trap_ctrl side
  modport slave (
    input  wb_valid, exc_valid, exc_code, mret_wb, pipe_busy,
           extern_intr, timer_intr, software_intr, mstatus_mie, mie, mtvec, mepc,
`ifdef TRAP_CTRL_NMI_EN
           nmi,
`endif
    output halt_if, flush_req, pc_set, pc_target, mepc_updata, mepc_mux,
           mcause_update, mcause, is_mret, trap_busy
  );

  // pipeline / CSR side
  modport master (
    output wb_valid, exc_valid, exc_code, mret_wb, pipe_busy,
           extern_intr, timer_intr, software_intr, mstatus_mie, mie, mtvec, mepc,
`ifdef TRAP_CTRL_NMI_EN
           nmi,
`endif
    input  halt_if, flush_req, pc_set, pc_target, mepc_updata, mepc_mux,
           mcause_update, mcause, is_mret, trap_busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Takes WB exceptions and MRET in the
// same cycle, drains the pipe before taking interrupts, then redirects fetch.
// Optional: TRAP_CTRL_NMI_EN adds a sticky edge-triggered NMI above everything.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit          VEC_EN     = 1'b1,
  parameter int unsigned DRAIN_MAX  = 15
`ifdef TRAP_CTRL_NMI_EN
  ,
  parameter logic [31:0] NMI_VECTOR = 32'h0000_0100
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  trap_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRAIN    = 2'd1;
  localparam logic [1:0] S_TRAP     = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;

  logic [2:0]  src;
  logic        irq_pend;
  logic [4:0]  irq_code;
  logic [31:0] base;
  logic [31:0] irq_tgt;

  // enabled sources ordered {MEI, MTI, MSI}
  assign src      = {bus.extern_intr, bus.timer_intr, bus.software_intr} &
                    {bus.mie[11], bus.mie[7], bus.mie[3]};
  assign irq_pend = bus.mstatus_mie & (|src);
  // MEI > MSI > MTI
  assign irq_code = src[2] ? 5'd11 : (src[0] ? 5'd3 : 5'd7);
  assign base     = {bus.mtvec[31:2], 2'b00};
  assign irq_tgt  = (VEC_EN && bus.mtvec[1:0] == 2'b01) ?
                    base + {25'd0, irq_code, 2'b00} : base;

  logic unused_ok;
  assign unused_ok = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0],
                       bus.mepc[0]};

`ifdef TRAP_CTRL_NMI_EN
  logic nmi_q, nmi_flag_q, nmi_flag_d, nmi_sel_q, nmi_sel_d, nmi_rise;
  assign nmi_rise = bus.nmi & ~nmi_q;
`endif

  // next state, target latch and all strobes; everything forced quiet in reset
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    tgt_d             = tgt_q;
    bus.halt_if       = 1'b0;
    bus.flush_req     = 1'b0;
    bus.pc_set        = 1'b0;
    bus.mepc_updata   = 1'b0;
    bus.mepc_mux      = MEPC_PC_WB;
    bus.mcause_update = 1'b0;
    bus.mcause        = '0;
    bus.is_mret       = 1'b0;
`ifdef TRAP_CTRL_NMI_EN
    nmi_flag_d        = nmi_flag_q | nmi_rise;
    nmi_sel_d         = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DRAIN: begin
        if (state_q == S_DRAIN) begin
          bus.halt_if = 1'b1;
          cnt_d       = cnt_q + 8'd1;
        end
`ifdef TRAP_CTRL_NMI_EN
        if (nmi_flag_q) begin
          state_d   = S_TRAP;
          nmi_sel_d = 1'b1;
        end else
`endif
        if (bus.exc_valid && bus.wb_valid) begin
          // a pending interrupt is simply retried from IDLE after REDIRECT
          bus.mcause_update = 1'b1;
          bus.mepc_updata   = 1'b1;
          bus.mcause        = {1'b0, bus.exc_code};
          bus.flush_req     = 1'b1;
          tgt_d             = base;
          state_d           = S_REDIRECT;
        end else if (bus.mret_wb && bus.wb_valid) begin
          bus.is_mret   = 1'b1;
          bus.flush_req = 1'b1;
          tgt_d         = {bus.mepc[31:1], 1'b0};
          state_d       = S_REDIRECT;
        end else if (state_q == S_IDLE) begin
          if (irq_pend) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end else if (!irq_pend) begin
          state_d = S_IDLE;
        end else if (!bus.pipe_busy || cnt_q == 8'(DRAIN_MAX)) begin
          state_d = S_TRAP;
        end
      end
      S_TRAP: begin
        bus.halt_if = 1'b1;
`ifdef TRAP_CTRL_NMI_EN
        if (nmi_sel_q) begin
          bus.mcause_update = 1'b1;
          bus.mepc_updata   = 1'b1;
          bus.mepc_mux      = MEPC_PC_IF;
          bus.mcause        = {1'b1, 5'h1F};
          bus.flush_req     = 1'b1;
          tgt_d             = NMI_VECTOR;
          nmi_flag_d        = nmi_rise;
          state_d           = S_REDIRECT;
        end else
`endif
        if (irq_pend) begin
          bus.mcause_update = 1'b1;
          bus.mepc_updata   = 1'b1;
          bus.mepc_mux      = MEPC_PC_IF;
          bus.mcause        = {1'b1, irq_code};
          bus.flush_req     = 1'b1;
          tgt_d             = irq_tgt;
          state_d           = S_REDIRECT;
        end else begin
          // source vanished on the last cycle: nothing left to take
          state_d = S_IDLE;
        end
      end
      default: begin  // S_REDIRECT
        bus.pc_set    = 1'b1;
        bus.flush_req = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
    if (!reset_n) begin
      bus.halt_if       = 1'b0;
      bus.flush_req     = 1'b0;
      bus.pc_set        = 1'b0;
      bus.mepc_updata   = 1'b0;
      bus.mepc_mux      = MEPC_PC_WB;
      bus.mcause_update = 1'b0;
      bus.mcause        = '0;
      bus.is_mret       = 1'b0;
    end
  end

  assign bus.pc_target = tgt_q;
  assign bus.trap_busy = reset_n && (state_q != S_IDLE);

  // state, drain counter and redirect target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef TRAP_CTRL_NMI_EN
  // nmi edge detector and sticky request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_q      <= 1'b0;
      nmi_flag_q <= 1'b0;
      nmi_sel_q  <= 1'b0;
    end else begin
      nmi_q      <= bus.nmi;
      nmi_flag_q <= nmi_flag_d;
      nmi_sel_q  <= nmi_sel_d;
    end
  end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed sequence with randomized operands, expectations from
// a rule-level model of trap cause and target.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  trap_ctrl_if bus ();

  trap_ctrl #(.VEC_EN(1'b1), .DRAIN_MAX(15)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: priority MEI > MSI > MTI over enabled sources {ext,tim,sw}
  function automatic logic [4:0] m_code(input logic [2:0] en);
    if (en[2]) return 5'd11;
    if (en[0]) return 5'd3;
    return 5'd7;
  endfunction

  // reference: aligned base, vectored only for interrupts in mode 1
  function automatic logic [31:0] m_tgt(input logic [31:0] tv, input bit irq,
                                        input logic [4:0] code);
    logic [31:0] b;
    b = tv & 32'hFFFF_FFFC;
    if (irq && tv[1:0] == 2'b01) return b + 32'(code) * 32'd4;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.wb_valid = 0; bus.exc_valid = 0; bus.exc_code = 0; bus.mret_wb = 0;
    bus.pipe_busy = 0; bus.extern_intr = 0; bus.timer_intr = 0;
    bus.software_intr = 0;
`ifdef TRAP_CTRL_NMI_EN
    bus.nmi = 0;
`endif
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mcu"}, 32'(bus.mcause_update), 0);
    chk({tag, "_pcset"}, 32'(bus.pc_set), 0);
    chk({tag, "_halt"}, 32'(bus.halt_if), 0);
    chk({tag, "_flush"}, 32'(bus.flush_req), 0);
    chk({tag, "_mret"}, 32'(bus.is_mret), 0);
    chk({tag, "_busy"}, 32'(bus.trap_busy), 0);
    chk({tag, "_mux"}, 32'(bus.mepc_mux), 32'(MEPC_PC_WB));
  endtask

  // runs a DRAIN with pipe_busy high, releasing it in drain cycle rel (0=never)
  task automatic drain_run(input int rel, input int exp_n, input logic [31:0] tv);
    int n;
    bit trapped;
    n = 0; trapped = 0;
    bus.mstatus_mie = 1; bus.mie = 32'h888; bus.mtvec = tv;
    bus.timer_intr = 1; bus.pipe_busy = 1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      if (c == rel) bus.pipe_busy = 0;
      #1;
      if (bus.mcause_update) begin trapped = 1; break; end
      if (bus.halt_if) n++;
      tick();
    end
    chk("drain_trapped", 32'(trapped), 1);
    chk("drain_cycles", 32'(n), 32'(exp_n));
    chk("drain_mcause", 32'(bus.mcause), {26'd0, 1'b1, 5'd7});
    tick();
    bus.timer_intr = 0; bus.pipe_busy = 0;
    #1;
    chk("drain_pcset", 32'(bus.pc_set), 1);
    chk("drain_tgt", bus.pc_target, m_tgt(tv, 1, 5'd7));
    tick();
  endtask

  initial begin
    logic [31:0] tv, mp, mie_r, r;
    logic [4:0]  code;
    logic [2:0]  s, en;

    // reset holds everything quiet even with events present
    quiet();
    bus.mtvec = 32'h8000_0000; bus.mepc = 0; bus.mstatus_mie = 1; bus.mie = '1;
    bus.wb_valid = 1; bus.exc_valid = 1; bus.mret_wb = 1; bus.extern_intr = 1;
    #1;
    check_quiet("rst");
    chk("rst_tgt", bus.pc_target, 0);
    tick();
    check_quiet("rst2");
    quiet();
    reset_n = 1;
    tick();

    // exceptions: same-cycle strobes, pc_set one cycle later
    for (int i = 0; i < 5; i++) begin
      tv   = (i == 0) ? 32'h8000_0000 : $urandom;
      code = (i == 0) ? 5'd2 : 5'($urandom_range(0, 31));
      bus.mtvec = tv; bus.mstatus_mie = 0;
      bus.exc_valid = 1; bus.wb_valid = 1; bus.exc_code = code;
      #1;
      chk("exc_mcu", 32'(bus.mcause_update), 1);
      chk("exc_mepc_upd", 32'(bus.mepc_updata), 1);
      chk("exc_mcause", 32'(bus.mcause), {27'd0, code});
      chk("exc_mux", 32'(bus.mepc_mux), 32'(MEPC_PC_WB));
      chk("exc_flush", 32'(bus.flush_req), 1);
      tick();
      quiet();
      #1;
      chk("exc_pcset", 32'(bus.pc_set), 1);
      chk("exc_tgt", bus.pc_target, m_tgt(tv, 0, code));
      chk("exc_mcu_once", 32'(bus.mcause_update), 0);
      tick();
      chk("exc_hold", bus.pc_target, m_tgt(tv, 0, code));
      chk("exc_idle", 32'(bus.trap_busy), 0);
    end

    // MRET
    for (int i = 0; i < 3; i++) begin
      mp = (i == 0) ? 32'h0000_1235 : $urandom;
      bus.mepc = mp; bus.mret_wb = 1; bus.wb_valid = 1;
      #1;
      chk("mret_strobe", 32'(bus.is_mret), 1);
      chk("mret_flush", 32'(bus.flush_req), 1);
      chk("mret_mcu", 32'(bus.mcause_update), 0);
      tick();
      quiet();
      #1;
      chk("mret_pcset", 32'(bus.pc_set), 1);
      chk("mret_tgt", bus.pc_target, mp & 32'hFFFF_FFFE);
      tick();
    end

    // interrupts with no drain wait
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        tv = 32'h8000_0001; mie_r = 32'h888; s = 3'b110;
      end else begin
        r = $urandom; tv = {r[31:2], 1'b0, 1'($urandom_range(0, 1))};
        mie_r = $urandom; s = 3'($urandom_range(0, 7));
      end
      en = s & {mie_r[11], mie_r[7], mie_r[3]};
      if (en == 0) begin s[2] = 1; mie_r[11] = 1; en = s & {mie_r[11], mie_r[7], mie_r[3]}; end
      code = m_code(en);
      bus.mtvec = tv; bus.mie = mie_r; bus.mstatus_mie = 1; bus.pipe_busy = 0;
      {bus.extern_intr, bus.timer_intr, bus.software_intr} = s;
      #1;
      chk("irq_idle_halt", 32'(bus.halt_if), 0);
      chk("irq_idle_mcu", 32'(bus.mcause_update), 0);
      tick();
      chk("irq_drain_halt", 32'(bus.halt_if), 1);
      chk("irq_drain_mcu", 32'(bus.mcause_update), 0);
      tick();
      chk("irq_trap_mcu", 32'(bus.mcause_update), 1);
      chk("irq_mcause", 32'(bus.mcause), {26'd0, 1'b1, code});
      chk("irq_mux", 32'(bus.mepc_mux), 32'(MEPC_PC_IF));
      chk("irq_halt", 32'(bus.halt_if), 1);
      tick();
      quiet();
      #1;
      chk("irq_pcset", 32'(bus.pc_set), 1);
      chk("irq_tgt", bus.pc_target, m_tgt(tv, 1, code));
      tick();
      chk("irq_done", 32'(bus.trap_busy), 0);
    end

    // disabled globally: no drain
    bus.mstatus_mie = 0; bus.mie = '1; bus.extern_intr = 1;
    tick();
    chk("mie_off_halt", 32'(bus.halt_if), 0);
    quiet();

    // drain bounded by DRAIN_MAX, and early release
    drain_run(0, 16, 32'h8000_0001);
    drain_run(5, 5, 32'h4000_0001);

    // exception aborts DRAIN; interrupt retried afterwards
    tv = 32'h8000_0001;
    bus.mtvec = tv; bus.mstatus_mie = 1; bus.mie = 32'h888;
    bus.extern_intr = 1; bus.pipe_busy = 1;
    tick(); tick();
    bus.exc_valid = 1; bus.wb_valid = 1; bus.exc_code = 5'd11;
    #1;
    chk("abort_halt", 32'(bus.halt_if), 1);
    chk("abort_mcu", 32'(bus.mcause_update), 1);
    chk("abort_mcause", 32'(bus.mcause), 32'h0B);
    chk("abort_mux", 32'(bus.mepc_mux), 32'(MEPC_PC_WB));
    tick();
    bus.exc_valid = 0; bus.wb_valid = 0;
    #1;
    chk("abort_pcset", 32'(bus.pc_set), 1);
    chk("abort_tgt", bus.pc_target, m_tgt(tv, 0, 5'd11));
    tick();
    chk("retry_idle", 32'(bus.trap_busy), 0);
    tick();
    chk("retry_drain", 32'(bus.halt_if), 1);
    // source removed while draining: back to IDLE
    bus.extern_intr = 0;
    tick();
    chk("drop_busy", 32'(bus.trap_busy), 0);
    chk("drop_halt", 32'(bus.halt_if), 0);

    // reset in the middle of DRAIN
    bus.timer_intr = 1; bus.pipe_busy = 1;
    tick(); tick();
    chk("pre_rst_drain", 32'(bus.halt_if), 1);
    bus.exc_valid = 1; bus.wb_valid = 1;
    reset_n = 0;
    #1;
    check_quiet("rst_drain");
    chk("rst_drain_tgt", bus.pc_target, 0);
    tick();
    quiet();
    reset_n = 1;
    tick();
    check_quiet("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
